// File: rtl/seq_comparator_nbit.sv
// rtl/seq_comparator_nbit.sv - digit-serial MSB-first magnitude comparator, unsigned or signed
module seq_comparator_nbit #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             e,
  output logic             g,
  output logic             l
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t                    state, state_nxt;
  logic [WIDTH-1:0]          a_q, b_q;
  logic [KW-1:0]             k;
  logic [BITS_PER_CYCLE-1:0] dig_a, dig_b;
  logic [WIDTH-1:0]          msb_flip;
  logic                      last_digit;
  logic                      accept;

  // Operands shift left after each equal digit, so the current digit is always the top slice.
  assign dig_a      = a_q[WIDTH-1 -: BITS_PER_CYCLE];
  assign dig_b      = b_q[WIDTH-1 -: BITS_PER_CYCLE];
  assign last_digit = (k == KW'(N - 1));
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_flip   = {signed_mode, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        busy = 1'b1;
        if ((dig_a != dig_b) || last_digit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CMP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      k     <= '0;
      e     <= 1'b0;
      g     <= 1'b0;
      l     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= a ^ msb_flip;
        b_q <= b ^ msb_flip;
        k   <= '0;
      end else if (state == CMP) begin
        if (dig_a != dig_b) begin
          e <= 1'b0;
          g <= (dig_a > dig_b);
          l <= (dig_a < dig_b);
        end else if (last_digit) begin
          e <= 1'b1;
          g <= 1'b0;
          l <= 1'b0;
        end else begin
          a_q <= a_q << BITS_PER_CYCLE;
          b_q <= b_q << BITS_PER_CYCLE;
          k   <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seq_comparator_nbit.md
Name: seq_comparator_nbit

Overview:
- Parametrised, digit-serial magnitude comparator; successor to the 2-bit combinational e/g/l comparator.
- Compares two WIDTH-bit operands MSB-first, BITS_PER_CYCLE bits per clock, under a start/busy/done handshake.
- Terminates early on the first differing digit.
- Supports unsigned and two's-complement signed modes.
- Used where wide compares must not sit in one combinational path (threshold checks, sort/priority units).

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- BITS_PER_CYCLE, 2, digit width compared per clock; must divide WIDTH; 1 <= BITS_PER_CYCLE <= WIDTH.
- Derived: N = WIDTH / BITS_PER_CYCLE digits. Digit 0 is the most significant.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a compare; sampled only when busy=0
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when e/g/l hold a new result
- e  output  1  A == B
- g  output  1  A > B
- l  output  1  A < B

Behaviour:
- Reset:
  - rst high at a clock edge forces state IDLE and busy=0, done=0, e=0, g=0, l=0.
  - The internal operand registers and digit counter are cleared.
  - Reset asserted mid-compare aborts that compare. No done pulse is produced for it.
- States: IDLE, CMP, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1, latch a, b and signed_mode. If signed_mode=1, invert the MSB of both latched operands; signed order then equals unsigned order.
  - Set the digit counter k=0 and go to CMP.
- CMP:
  - busy=1, done=0.
  - Each cycle, compare digit k of the latched operands (bits WIDTH-1-k*BITS_PER_CYCLE down to WIDTH-(k+1)*BITS_PER_CYCLE) as unsigned values.
  - If the digits differ, register g = (digitA > digitB) and l = (digitA < digitB), with e=0. Go to DONE.
  - If the digits are equal and k == N-1, register e=1, g=0, l=0. Go to DONE.
  - Otherwise k <= k+1 and stay in CMP.
- DONE:
  - busy=0, done=1 for exactly this cycle; e/g/l are valid.
  - Next state is IDLE. If start=1 in this cycle, the new operands are latched and the next state is CMP instead (back-to-back operation).
- Latency, with start sampled at edge 0:
  - First mismatch at digit k: done is high in the cycle after edge k+1.
  - All digits equal: done is high in the cycle after edge N.
  - Worst case is N+1 cycles from start to done.
  - Throughput is one compare per N+1 cycles.
- Result outputs:
  - e/g/l change only on entry to DONE or on reset. They hold until the next result.
  - After any completed compare, exactly one of e/g/l is 1.
- Input handling:
  - start while busy=1 is ignored, with no queueing.
  - a, b and signed_mode are don't-care except when start is accepted. Operand changes during CMP have no effect.
- Boundary cases:
  - BITS_PER_CYCLE == WIDTH: N=1, so every compare takes 2 cycles.
  - Signed mode, most negative vs most positive value: resolved at digit 0.
  - start and rst high together: rst wins.

Test Plan (WIDTH=8, BITS_PER_CYCLE=2, N=4; start pulsed at edge 0):
- Equality, full length: a=0xA5, b=0xA5, signed_mode=0 -> busy high for 4 cycles; done pulses in cycle 5; e=1, g=0, l=0.
- Early termination: a=0x80, b=0x7F, signed_mode=0 -> digit 0 differs; done in cycle 2; g=1, e=0, l=0.
- Signed mode, same operands: a=0x80 (-128), b=0x7F (+127), signed_mode=1 -> done in cycle 2; l=1. Also a=0xFF (-1), b=0x01, signed_mode=1 -> l=1.
- Last-digit decision and busy protection: a=0x12, b=0x13 -> done in cycle 5 with l=1. A second start with a=0xFF, b=0x00 pulsed in cycle 2 is ignored; no extra done follows.
- Back-to-back: assert start in the DONE cycle with a=0x40, b=0x30 -> busy returns the next cycle; g=1 two cycles later. The earlier result holds until then.
- Reset mid-operation: start a=0x12, b=0x13, then rst=1 in cycle 3 -> busy=0, done=0, e=g=l=0 the next cycle. No done pulse ever appears for the aborted compare. A new start afterwards works normally.
